// File: rtl/ram_port_arbiter.sv
// Two-master OBI-style arbiter in front of a single RAM data port.
// Round-robin or fixed priority with starvation relief, plus a debugger lock.
module ram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned PRIO_MODE    = 0,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m0_req_i,
  output logic                    m0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_req_i,
  output logic                    m1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  input  logic                    m1_lock_i,
  output logic                    ram_req_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
  output logic                    lock_active_o,
  output logic [CNT_WIDTH-1:0]    conflict_cnt_o
);

  localparam int unsigned StarveWidth = $clog2(STARVE_LIMIT + 1);

  logic                   last_q;   // 0: m0 granted last, 1: m1 granted last
  logic                   owner_q;
  logic                   rvalid0_q;
  logic                   rvalid1_q;
  logic                   lock_q;
  logic [StarveWidth-1:0] starve_q;
  logic [CNT_WIDTH-1:0]   conflict_q;
  logic                   tie;
  logic                   m1_wins_tie;

  assign tie = m0_req_i & m1_req_i;

  always_comb begin
    m0_gnt_o = 1'b0;
    m1_gnt_o = 1'b0;
    if (PRIO_MODE == 0) begin
      m1_wins_tie = ~last_q;
    end else begin
      m1_wins_tie = (starve_q == StarveWidth'(STARVE_LIMIT));
    end
    if (!rst_i) begin
      if (lock_q) begin
        m1_gnt_o = m1_req_i;
      end else if (tie) begin
        m1_gnt_o = m1_wins_tie;
        m0_gnt_o = ~m1_wins_tie;
      end else begin
        m0_gnt_o = m0_req_i;
        m1_gnt_o = m1_req_i;
      end
    end
  end

  always_comb begin
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    if (m1_gnt_o) begin
      ram_addr_o  = m1_addr_i;
      ram_we_o    = m1_we_i;
      ram_be_o    = m1_be_i;
      ram_wdata_o = m1_wdata_i;
    end else if (m0_gnt_o) begin
      ram_addr_o  = m0_addr_i;
      ram_we_o    = m0_we_i;
      ram_be_o    = m0_be_i;
      ram_wdata_o = m0_wdata_i;
    end
  end

  assign ram_req_o = m0_gnt_o | m1_gnt_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      lock_q     <= 1'b0;
      starve_q   <= '0;
      conflict_q <= '0;
    end else begin
      rvalid0_q <= m0_gnt_o;
      rvalid1_q <= m1_gnt_o;
      if (m0_gnt_o || m1_gnt_o) begin
        owner_q <= m1_gnt_o;
        last_q  <= m1_gnt_o;
      end
      if (m1_gnt_o && m1_lock_i) begin
        lock_q <= 1'b1;
      end else if (!m1_lock_i) begin
        lock_q <= 1'b0;
      end
      if (PRIO_MODE != 0 && m1_req_i && !m1_gnt_o) begin
        if (starve_q != StarveWidth'(STARVE_LIMIT)) begin
          starve_q <= starve_q + 1'b1;
        end
      end else begin
        starve_q <= '0;
      end
      if (tie && conflict_q != '1) begin
        conflict_q <= conflict_q + 1'b1;
      end
    end
  end

  // Responses are suppressed while reset is held so a pending one is dropped.
  assign m0_rvalid_o    = rvalid0_q & ~owner_q & ~rst_i;
  assign m1_rvalid_o    = rvalid1_q & owner_q & ~rst_i;
  assign m0_rdata_o     = ram_rdata_i;
  assign m1_rdata_o     = ram_rdata_i;
  assign lock_active_o  = lock_q;
  assign conflict_cnt_o = conflict_q;

endmodule
